// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- client and memory-port bundle for mem_arbiter.
//   Client side : req, we, lock, addr, wdata (packed per client), gnt, rvalid, rdata.
//   Memory side : mem_en, mem_we, mem_addr, mem_di (to memory), mem_do (from memory).
// Modports:
//   slave  -- the arbiter: samples client requests and memory read data,
//             drives grants, read returns and the memory port.
//   master -- the environment: the clients plus the memory behind the port.
interface mem_arbiter_if #(
   parameter int N_CLIENTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [N_CLIENTS-1:0]            req;
   logic [N_CLIENTS-1:0]            we;
   logic [N_CLIENTS-1:0]            lock;
   logic [N_CLIENTS*ADDR_WIDTH-1:0] addr;
   logic [N_CLIENTS*DATA_WIDTH-1:0] wdata;
   logic [N_CLIENTS-1:0]            gnt;
   logic [N_CLIENTS-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]           rdata;
   logic                            mem_en;
   logic                            mem_we;
   logic [ADDR_WIDTH-1:0]           mem_addr;
   logic [DATA_WIDTH-1:0]           mem_di;
   logic [DATA_WIDTH-1:0]           mem_do;

   modport slave (
      input  req, we, lock, addr, wdata, mem_do,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_di
   );

   modport master (
      output req, we, lock, addr, wdata, mem_do,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_di
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter sharing one synchronous memory port
// among N_CLIENTS clients, one access per cycle.
// Ports:
//   clk   -- single clock, rising edge
//   reset -- synchronous, active-high
//   bus   -- mem_arbiter_if.slave (client requests/grants, read returns,
//            memory port)
// Timing: accept in cycle t (req&gnt) -> memory command in t+1 -> for reads,
// rvalid/rdata in t+2 (rdata is mem_do passed through on that cycle).
// Optional feature: define ARB_LOCK_EN to compile in burst locking, where a
// locked client keeps priority for up to MAX_BURST consecutive accepts.
module mem_arbiter #(
   parameter int N_CLIENTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   logic [PW-1:0]         ptr, ptr_nxt, ptr_inc, sel;
   logic [N_CLIENTS-1:0]  gnt_c, rd_s1, rvalid_q;
   logic                  found, sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr, mem_addr_q;
   logic [DATA_WIDTH-1:0] sel_di, mem_di_q, rdata_q;
   logic                  mem_en_q, mem_we_q;

   // Round-robin pick: first requester at or above ptr, else first below it.
   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt_c = '0;
      sel   = '0;
      found = 1'b0;
      for (int j = 0; j < N_CLIENTS; j++) begin
         if (!found && bus.req[j] && j >= int'(ptr)) begin
            gnt_c[j] = 1'b1;
            sel      = PW'(j);
            found    = 1'b1;
         end
      end
      for (int j = 0; j < N_CLIENTS; j++) begin
         if (!found && bus.req[j] && j < int'(ptr)) begin
            gnt_c[j] = 1'b1;
            sel      = PW'(j);
            found    = 1'b1;
         end
      end
      // Nothing is granted (and so nothing accepted) while reset is held.
      if (reset) begin
         gnt_c = '0;
         found = 1'b0;
      end
   end

   // Command fields of the winning client.
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_di   = '0;
      for (int j = 0; j < N_CLIENTS; j++) begin
         if (gnt_c[j]) begin
            sel_we   = bus.we[j];
            sel_addr = bus.addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            sel_di   = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ptr_inc = (int'(sel) == N_CLIENTS - 1) ? '0 : sel + PW'(1);

`ifdef ARB_LOCK_EN
   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   logic [7:0] burst_cnt, burst_nxt, burst_inc;
   logic       sel_lock;

   always_comb begin
      sel_lock = 1'b0;
      for (int j = 0; j < N_CLIENTS; j++) begin
         if (gnt_c[j]) sel_lock = bus.lock[j];
      end
   end

   // A nonzero count means the previous cycle was a locked accept by the
   // client ptr is parked on; anything else starts a fresh burst.
   always_comb begin
      ptr_nxt   = ptr;
      burst_nxt = '0;
      burst_inc = (burst_cnt != '0 && sel == ptr) ? burst_cnt + 8'd1 : 8'd1;
      if (found) begin
         if (sel_lock && burst_inc < BURST_MAX) begin
            ptr_nxt   = sel;
            burst_nxt = burst_inc;
         end else begin
            ptr_nxt = ptr_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) burst_cnt <= '0;
      else       burst_cnt <= burst_nxt;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{bus.lock, 8'(MAX_BURST)};

   always_comb ptr_nxt = found ? ptr_inc : ptr;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_di_q   <= '0;
         rd_s1      <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         ptr      <= ptr_nxt;
         mem_en_q <= found;
         mem_we_q <= found & sel_we;
         if (found) begin
            mem_addr_q <= sel_addr;
            mem_di_q   <= sel_di;
         end
         // Read tag follows the command one stage behind; memory answers then.
         rd_s1    <= (found && !sel_we) ? gnt_c : '0;
         rvalid_q <= rd_s1;
         if (|rvalid_q) rdata_q <= bus.mem_do;
      end
   end

   // Outputs are forced to zero combinationally so they read zero during the
   // very first cycle reset is high, before the registers have cleared.
   assign bus.gnt      = gnt_c;
   assign bus.rvalid   = reset ? '0 : rvalid_q;
   assign bus.rdata    = reset ? '0 : ((|rvalid_q) ? bus.mem_do : rdata_q);
   assign bus.mem_en   = reset ? 1'b0 : mem_en_q;
   assign bus.mem_we   = reset ? 1'b0 : mem_we_q;
   assign bus.mem_addr = reset ? '0 : mem_addr_q;
   assign bus.mem_di   = reset ? '0 : mem_di_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 2, number of requesting clients (range 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum consecutive locked grants (range 1..255; used only with ARB_LOCK_EN).
REQ-005 SHALL have one clock and a synchronous, active-high reset:
  clk  in  1  single clock; all state updates on rising edge.
  reset  in  1  synchronous, active-high reset.
  req  in  N_CLIENTS  per-client access request.
  we  in  N_CLIENTS  per-client write enable (1 write, 0 read).
  addr  in  N_CLIENTS*ADDR_WIDTH  per-client address, client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
  wdata  in  N_CLIENTS*DATA_WIDTH  per-client write data, packed like addr.
  lock  in  N_CLIENTS  per-client burst lock (ignored without ARB_LOCK_EN).
  gnt  out  N_CLIENTS  one-hot-or-zero grant; access accepted in the cycle req[i]&gnt[i].
  rvalid  out  N_CLIENTS  one-cycle pulse, read data for client i on rdata.
  rdata  out  DATA_WIDTH  read data, shared by all clients.
  mem_en  out  1  memory port enable.
  mem_we  out  1  memory port write enable.
  mem_addr  out  ADDR_WIDTH  memory port address.
  mem_di  out  DATA_WIDTH  memory port write data.
  mem_do  in  DATA_WIDTH  memory port read data, valid one cycle after mem_en&~mem_we.

Function
REQ-006 gnt SHALL be combinational from req and the priority pointer; at most one bit set; gnt[i] set only if req[i].
REQ-007 Round-robin: search starts at pointer ptr, ascending, wrapping N_CLIENTS-1 -> 0; first requesting client wins.
REQ-008 On an accepted access by client k, ptr SHALL become (k+1) mod N_CLIENTS next cycle; no accept -> ptr unchanged.
REQ-009 One access SHALL be accepted every cycle while any req is high (full throughput, no idle bubbles).
REQ-010 Accepted access in cycle t SHALL appear registered on mem_en=1, mem_we, mem_addr, mem_di in cycle t+1.
REQ-011 No accept in cycle t -> mem_en=0 and mem_we=0 in t+1; mem_addr/mem_di hold last value.
REQ-012 Read accepted in cycle t SHALL give rvalid[k]=1 and rdata=mem_do in cycle t+2 (fixed 2-cycle latency); writes never raise rvalid.
REQ-013 rvalid SHALL be one-hot-or-zero; rdata holds its last value when no rvalid.
REQ-014 Back-to-back reads from different clients SHALL return in acceptance order, one per cycle.
REQ-015 Write in cycle t followed by read of the same address in t+1 SHALL return the written data (memory write-first ordering preserved by in-order issue).
REQ-016 N_CLIENTS=1 SHALL degenerate to gnt[0]=req[0] with identical latency.

Reset
REQ-017 While reset=1: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_di=0, rdata=0, ptr=0, burst counter=0.
REQ-018 Reset mid-operation SHALL drop all in-flight accesses; no rvalid for reads accepted before or during reset.
REQ-019 First accept possible in the first cycle with reset=0.

Configuration
REQ-020 Macro ARB_LOCK_EN SHALL compile in burst locking; absent, lock is ignored and REQ-007/008 apply unconditionally.
REQ-021 With ARB_LOCK_EN: if client k is accepted with lock[k]=1, k SHALL keep priority next cycle (ptr stays k) while req[k]&lock[k].
REQ-022 With ARB_LOCK_EN: after MAX_BURST consecutive locked accepts by the same client, ptr SHALL advance to (k+1) mod N_CLIENTS and the burst counter clear.
REQ-023 With ARB_LOCK_EN: lock[k] or req[k] dropping SHALL clear the burst counter and resume REQ-008 rotation.

Verification
REQ-024 Reset then req=2'b11, both reads, addr0=0x0010, addr1=0x0020 -> gnt alternates 01,10,01...; rvalid pulses alternate with matching rdata 2 cycles after each accept.
REQ-025 Client 0 writes 0xDEADBEEF to 0x0005 at t, client 0 reads 0x0005 at t+1 -> rvalid[0] at t+3, rdata=0xDEADBEEF.
REQ-026 N_CLIENTS=4, ptr=3, req=4'b0101 -> gnt=4'b0001 (wrap), next cycle gnt=4'b0100.
REQ-027 Reads accepted at t and t+1, reset=1 at t+1 for one cycle -> no rvalid at t+2 or t+3; all outputs zero during reset.
REQ-028 ARB_LOCK_EN, MAX_BURST=4, req=2'b11, lock[0]=1 -> client 0 granted 4 consecutive cycles, then client 1 once, then client 0 again.
REQ-029 Without ARB_LOCK_EN, same stimulus as REQ-028 -> strict alternation 01,10,01,10.
